word_serializer_msb: RTL and testbench

Parallel-to-serial front end for the bit-serial arithmetic path. It accepts WIDTH-bit words over a valid/ready handshake and emits each word MSB-first, one bit per transfer, on a bit-level valid/ready stream. Per-bit start/end-of-word markers let the downstream bit-serial divisibility checker restart on every word; its `x_i` is driven from `x_o`. A one-entry holding register allows back-to-back words with no bubble between them.

---
 rtl/word_serializer_msb_if.sv | 25 ++
 rtl/word_serializer_msb.sv | 102 ++++++++++
 tb/tb_word_serializer_msb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_msb_if.sv
// rtl/word_serializer_msb_if.sv - word-in / bit-out stream bundle for the MSB-first serializer
interface word_serializer_msb_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word_i;
    logic             word_valid_i;
    logic             word_ready_o;
    logic             clear_i;
    logic             x_o;
    logic             x_valid_o;
    logic             bit_ready_i;
    logic             sof_o;
    logic             eof_o;
    logic             busy_o;

    modport master (
        output word_i, word_valid_i, clear_i, bit_ready_i,
        input  word_ready_o, x_o, x_valid_o, sof_o, eof_o, busy_o
    );

    modport slave (
        input  word_i, word_valid_i, clear_i, bit_ready_i,
        output word_ready_o, x_o, x_valid_o, sof_o, eof_o, busy_o
    );
endinterface

// File: rtl/word_serializer_msb.sv
// rtl/word_serializer_msb.sv - parallel word to MSB-first bit stream with one-word holding register
module word_serializer_msb #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    word_serializer_msb_if.slave  s
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic             ready_q, ready_d;

    logic act;
    logic accept;
    logic xfer;
    logic last;
    logic consumed;

    assign act    = (state_q == SHIFT);
    assign accept = s.word_valid_i & ready_q;
    assign xfer   = act & s.bit_ready_i;
    assign last   = xfer & (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        consumed = 1'b0;

        if (s.clear_i) begin
            state_d  = IDLE;
            hold_v_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (xfer && !last) begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
            end else if (last || !act) begin
                // The held word always wins the reload; a new word can only be
                // accepted here when nothing is held, since ready tracks hold_v.
                if (hold_v_q) begin
                    shift_d  = hold_q;
                    hold_v_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end else if (accept) begin
                    shift_d  = s.word_i;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                    consumed = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            if (accept && act && !consumed) begin
                hold_d   = s.word_i;
                hold_v_d = 1'b1;
            end
        end

        ready_d = !s.clear_i && !hold_v_d;
    end

    assign s.word_ready_o = ready_q;
    assign s.x_valid_o    = act;
    assign s.x_o          = shift_q[WIDTH-1] & act;
    assign s.sof_o        = act & (cnt_q == '0);
    assign s.eof_o        = act & (cnt_q == CNT_LAST);
    assign s.busy_o       = act | hold_v_q;
endmodule

// File: tb/tb_word_serializer_msb.sv
// tb/tb_word_serializer_msb.sv - directed table and sequence checks for word_serializer_msb
module tb_word_serializer_msb;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    word_serializer_msb_if #(.WIDTH(8)) bus ();

    word_serializer_msb #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] word;
        logic       bready;
        logic       clr;
        logic       e_xv;
        logic       e_x;
        logic       e_sof;
        logic       e_eof;
        logic       e_rdy;
        logic       e_busy;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic xv, input logic x, input logic sof,
                           input logic eof, input logic rdy, input logic busy);
        chk({tag, ".x_valid"}, 32'(bus.x_valid_o), 32'(xv));
        chk({tag, ".x"}, 32'(bus.x_o), 32'(x));
        chk({tag, ".sof"}, 32'(bus.sof_o), 32'(sof));
        chk({tag, ".eof"}, 32'(bus.eof_o), 32'(eof));
        chk({tag, ".ready"}, 32'(bus.word_ready_o), 32'(rdy));
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'(busy));
    endtask

    task automatic drive(input logic v, input logic [7:0] w, input logic br, input logic clr);
        bus.word_valid_i = v;
        bus.word_i       = w;
        bus.bit_ready_i  = br;
        bus.clear_i      = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] b2b;
        logic [7:0]  bp;
        logic [7:0]  cw;
        logic        rdy_e;
        int          xfers;
        int          idx;

        n_cmp  = 0;
        n_fail = 0;

        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset held with random inputs
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            step();
            chk_all($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        reset_n = 1'b1;
        step();
        chk_all("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Single word 0xA5 from the table
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].valid, tbl[i].word, tbl[i].bready, tbl[i].clr);
            step();
            chk_all($sformatf("a5_%0d", i), tbl[i].e_xv, tbl[i].e_x, tbl[i].e_sof,
                    tbl[i].e_eof, tbl[i].e_rdy, tbl[i].e_busy);
        end

        // Back-to-back 0x81, 0x7E, then 0xC3 accepted once the hold register frees
        b2b = 24'h817EC3;
        for (int e = 0; e <= 24; e++) begin
            cw = (e == 0) ? 8'h81 : ((e == 1) ? 8'h7E : 8'hC3);
            drive(e <= 9, cw, 1'b1, 1'b0);
            step();
            if (e < 24) begin
                rdy_e = (e == 0) || (e == 8) || (e >= 16);
                chk_all($sformatf("b2b_%0d", e), 1'b1, b2b[23-e], (e % 8) == 0,
                        (e % 8) == 7, rdy_e, 1'b1);
            end else begin
                chk_all("b2b_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end

        // Backpressure: 0x3C with bit_ready alternating 0,1
        bp    = 8'h3C;
        xfers = 0;
        drive(1'b1, bp, 1'b0, 1'b0);
        step();
        chk_all("bp_0", 1'b1, bp[7], 1'b1, 1'b0, 1'b1, 1'b1);
        for (int e = 1; e <= 16; e++) begin
            drive(1'b0, 8'h00, (e % 2) == 0, 1'b0);
            if (bus.x_valid_o && bus.bit_ready_i) xfers++;
            step();
            if (e < 16) begin
                idx = e / 2;
                chk_all($sformatf("bp_%0d", e), 1'b1, bp[7-idx], idx == 0, idx == 7, 1'b1, 1'b1);
            end else begin
                chk_all("bp_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end
        chk("bp_xfers", 32'(xfers), 32'd8);

        // Clear after 3 bits of 0xF0 with 0x0F held
        drive(1'b1, 8'hF0, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'h0F, 1'b1, 1'b0);
        step();
        chk("clr_held_ready", 32'(bus.word_ready_o), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        step();
        chk("clr_pre_busy", 32'(bus.busy_o), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        step();
        chk("clr_xv", 32'(bus.x_valid_o), 32'd0);
        chk("clr_busy", 32'(bus.busy_o), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        chk_all("clr_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cw = 8'h55;
        for (int e = 0; e <= 8; e++) begin
            drive(e == 0, cw, 1'b1, 1'b0);
            step();
            if (e < 8)
                chk_all($sformatf("c55_%0d", e), 1'b1, cw[7-e], e == 0, e == 7, 1'b1, 1'b1);
            else
                chk_all("c55_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Asynchronous reset pulse mid-word
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        chk("ar_pre_busy", 32'(bus.busy_o), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_all("ar_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        reset_n = 1'b1;
        step();
        chk_all("ar_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("ar_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
